// File: rtl/hazard_ctrl_pkg.sv
// Shared processor definitions used by the hazard controller.
// Holds the controller state encoding and the hard-wired zero register index.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        HALT     = 2'b10
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_wait_timer.sv
// Counts consecutive data-memory wait cycles and flags when the limit is reached.
module hazard_ctrl_wait_timer #(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic inc,
    output logic timeout
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt;

    assign timeout = (cnt == CW'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(1);
        end else if (inc && !timeout) begin
            cnt <= cnt + CW'(1);
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, taken-branch flushes,
// data-memory freeze with timeout-to-halt, and saturating performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int size     = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [4:0]      ID_Rs1,
    input  logic [4:0]      ID_Rs2,
    input  logic            ID_UsesRs2,
    input  logic [4:0]      EX_Rd,
    input  logic            EX_MemRead,
    input  logic            EX_BranchTaken,
    input  logic            DMem_Req,
    input  logic            DMem_Ready,
    output logic            PC_Write,
    output logic            IFID_Write,
    output logic            IDEX_Write,
    output logic            EXMEM_Write,
    output logic            IFID_Flush,
    output logic            IDEX_Flush,
    output logic            MEMWB_Flush,
    output logic            Halted,
    output logic [1:0]      State,
    output logic [size-1:0] StallCycles,
    output logic [size-1:0] FlushCount
);

    state_t state;
    logic   freeze;
    logic   load_use;
    logic   branch_eff;
    logic   timeout;
    logic   wait_load;
    logic   wait_inc;

    assign State = state;

    assign freeze   = DMem_Req && !DMem_Ready && (state != HALT);
    assign load_use = EX_MemRead && (EX_Rd != REG_ZERO) &&
                      ((EX_Rd == ID_Rs1) || (ID_UsesRs2 && (EX_Rd == ID_Rs2)));

    // A branch only counts on the cycle its flush is actually applied.
    assign branch_eff = !RST && (state != HALT) && !freeze && EX_BranchTaken;

    assign wait_load = !RST && freeze && (state == RUN);
    assign wait_inc  = !RST && freeze && (state == MEM_WAIT);

    hazard_ctrl_wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_wait_timer (
        .clk    (CLK),
        .rst    (RST),
        .load   (wait_load),
        .inc    (wait_inc),
        .timeout(timeout)
    );

    always_comb begin
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        IDEX_Write  = 1'b1;
        EXMEM_Write = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        MEMWB_Flush = 1'b0;
        Halted      = 1'b0;
        if (RST) begin
            PC_Write    = 1'b0;
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            MEMWB_Flush = 1'b1;
        end else if (state == HALT) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Write  = 1'b0;
            EXMEM_Write = 1'b0;
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            MEMWB_Flush = 1'b1;
            Halted      = 1'b1;
        end else if (freeze) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Write  = 1'b0;
            EXMEM_Write = 1'b0;
            MEMWB_Flush = 1'b1;
        end else if (EX_BranchTaken) begin
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
        end else if (load_use) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Flush  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= RUN;
            StallCycles <= '0;
            FlushCount  <= '0;
        end else begin
            case (state)
                RUN:      if (freeze) state <= MEM_WAIT;
                MEM_WAIT: begin
                    if (!freeze)      state <= RUN;
                    else if (timeout) state <= HALT;
                end
                HALT:     state <= HALT;
                default:  state <= RUN;
            endcase
            if (!PC_Write && (StallCycles != '1)) begin
                StallCycles <= StallCycles + 1'b1;
            end
            if (branch_eff && (FlushCount != '1)) begin
                FlushCount <= FlushCount + 1'b1;
            end
        end
    end

endmodule
